operand_fetch_stage: RTL and testbench
======================================

Name: operand_fetch_stage

Overview:
- Decode/operand-fetch stage that sits directly upstream of Reg_16bit_file's read ports and downstream of its write port.
- Drives the register-file read addresses and captures BusA/BusB into an output pipeline register for execute.
- Tracks pending register writes in a 16-entry busy-bit scoreboard and stalls on RAW/WAW hazards.
- Bypasses same-cycle write-back data, because the register file commits on the clock edge.

Parameters:
- DATA_W, 16, operand/data width
- ADDR_W, 4, register address width
- NREG, 16, number of architectural registers (2**ADDR_W)

Ports:
- clk  in  1  clock, all state on posedge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream instruction present
- in_ready  out  1  stage accepts instruction this cycle
- in_op  in  4  opcode, passed through unchanged
- in_src_a  in  ADDR_W  source A register
- in_src_b  in  ADDR_W  source B register
- in_uses_a  in  1  instruction reads src A
- in_uses_b  in  1  instruction reads src B
- in_dst  in  ADDR_W  destination register
- in_wen  in  1  instruction writes dst
- rf_addr_a  out  ADDR_W  to register file AddrA
- rf_addr_b  out  ADDR_W  to register file AddrB
- rf_bus_a  in  DATA_W  from register file BusA (combinational read)
- rf_bus_b  in  DATA_W  from register file BusB
- wb_wen  in  1  write-back strobe, same signal as RegWrite
- wb_addr  in  ADDR_W  write-back address, same as AddrC
- wb_data  in  DATA_W  write-back data, same as BusC
- flush  in  1  synchronous squash of the output register
- out_valid  out  1  execute-side instruction valid
- out_ready  in  1  execute accepts
- out_op  out  4  registered opcode
- out_dst  out  ADDR_W  registered destination
- out_wen  out  1  registered write enable
- out_opa  out  DATA_W  registered operand A
- out_opb  out  DATA_W  registered operand B

Behaviour:
- Reset (async, rst_n=0): out_valid=0, busy[15:0]=0, out_op/out_dst/out_wen/out_opa/out_opb=0. Reset mid-operation drops any held instruction.
- rf_addr_a=in_src_a and rf_addr_b=in_src_b, combinationally at all times.
- bypass_a = wb_wen && wb_addr==in_src_a. opa_next = bypass_a ? wb_data : rf_bus_a. Same rule for B.
- RAW hazard A: in_uses_a && busy[in_src_a] && !bypass_a. Same rule for B.
- WAW hazard: in_wen && busy[in_dst] && !(wb_wen && wb_addr==in_dst).
- space = !out_valid || out_ready.
- in_ready = space && !hazard_a && !hazard_b && !waw && !flush.
- in_ready is combinational from the in_* fields and wb_*; it does not depend on in_valid.
- Issue = in_valid && in_ready.
- On issue: load the output register with op/dst/wen/opa_next/opb_next and set out_valid=1. Latency is 1 cycle from acceptance to out_valid.
- Else if out_ready: out_valid=0.
- Else: hold all outputs unchanged.
- Scoreboard, per register r, next-state priority:
  - Issue with in_wen and in_dst==r sets busy[r]; this wins over a same-cycle clear.
  - Else flush with out_valid && out_wen && out_dst==r clears busy[r].
  - Else wb_wen && wb_addr==r clears busy[r].
  - Else busy[r] holds.
- Flush: next out_valid=0; no issue that cycle.
  - It only clears the busy bit of the squashed instruction. Older instructions already past this stage still clear their bits via write-back.
- At most one outstanding write per register, guaranteed by the WAW stall.
- Write-back to a non-busy register is legal (no-op on the scoreboard); the data still bypasses.
- Operands captured while out_valid && !out_ready are not refreshed. Correctness holds because hazards were resolved at capture.
- No special handling of R0; all 16 registers are ordinary.

Decomposition:
- Shared package: DATA_W/ADDR_W/NREG constants and opcode width typedef (4-bit op_t), also used by Reg_16bit_file and the execute stage.
- One natural sub-module, reg_scoreboard: busy bits with set/clear/flush-clear ports and a 3-port lookup (src_a, src_b, dst). The stage instantiates it beside the output register and bypass muxes.

Test Plan:
- Reset, preload R1=0x0011 and R2=0x0022, issue op=3 src_a=1 src_b=2, out_ready=1 -> next cycle out_valid=1, out_opa=0x0011, out_opb=0x0022.
- Issue writer dst=5 wen=1, then a reader with src_a=5 -> in_ready=0 until wb_wen=1 wb_addr=5 wb_data=0xBEEF. In that same cycle in_ready=1 and the captured out_opa=0xBEEF (bypass); busy[5]=0 afterwards.
- out_ready=0 with out_valid=1 for 3 cycles -> outputs held stable, in_ready=0; set out_ready=1 while a new instruction is waiting -> back-to-back transfer, out_valid stays 1.
- Issue wen dst=7 while a same-cycle wb clears R7 from an older write -> busy[7]=1 after the edge (set wins); a subsequent reader of R7 stalls.
- Output holds wen dst=9, flush=1 -> out_valid=0, busy[9]=0, and a following reader of R9 issues immediately with the register-file value.
- Assert rst_n=0 asynchronously mid-stall with busy[3]=1 -> out_valid=0 and all busy bits 0 without waiting for a clk edge.

Source files
------------

// File: rtl/operand_fetch_stage_pkg.sv
// Shared widths and opcode type for the register file, operand-fetch and execute stages.
package operand_fetch_stage_pkg;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned ADDR_W = 4;
   localparam int unsigned NREG   = 1 << ADDR_W;

   typedef logic [3:0] op_t;
endpackage

// File: rtl/operand_fetch_stage_reg_scoreboard.sv
// Busy-bit scoreboard: one bit per architectural register marking an outstanding write.
module reg_scoreboard
   import operand_fetch_stage_pkg::*;
#(
   parameter int unsigned ADDR_W = operand_fetch_stage_pkg::ADDR_W,
   parameter int unsigned NREG   = operand_fetch_stage_pkg::NREG
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              set_i,
   input  logic [ADDR_W-1:0] set_addr_i,
   input  logic              fclr_i,
   input  logic [ADDR_W-1:0] fclr_addr_i,
   input  logic              clr_i,
   input  logic [ADDR_W-1:0] clr_addr_i,
   input  logic [ADDR_W-1:0] look_a_i,
   input  logic [ADDR_W-1:0] look_b_i,
   input  logic [ADDR_W-1:0] look_d_i,
   output logic              busy_a_o,
   output logic              busy_b_o,
   output logic              busy_d_o
);

   logic [NREG-1:0] busy_q, busy_d;

   // A new write claim beats any same-cycle release of the same register.
   always_comb begin
      busy_d = busy_q;
      for (int unsigned r = 0; r < NREG; r++) begin
         if (set_i && set_addr_i == ADDR_W'(r))
            busy_d[r] = 1'b1;
         else if (fclr_i && fclr_addr_i == ADDR_W'(r))
            busy_d[r] = 1'b0;
         else if (clr_i && clr_addr_i == ADDR_W'(r))
            busy_d[r] = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         busy_q <= '0;
      else
         busy_q <= busy_d;
   end

   assign busy_a_o = busy_q[look_a_i];
   assign busy_b_o = busy_q[look_b_i];
   assign busy_d_o = busy_q[look_d_i];

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand-fetch stage: reads the register file, bypasses write-back, stalls on RAW/WAW
// hazards via a busy-bit scoreboard and registers the operands for execute.
module operand_fetch_stage
   import operand_fetch_stage_pkg::*;
#(
   parameter int unsigned DATA_W = operand_fetch_stage_pkg::DATA_W,
   parameter int unsigned ADDR_W = operand_fetch_stage_pkg::ADDR_W,
   parameter int unsigned NREG   = operand_fetch_stage_pkg::NREG
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_op,
   input  logic [ADDR_W-1:0] in_src_a,
   input  logic [ADDR_W-1:0] in_src_b,
   input  logic              in_uses_a,
   input  logic              in_uses_b,
   input  logic [ADDR_W-1:0] in_dst,
   input  logic              in_wen,
   output logic [ADDR_W-1:0] rf_addr_a,
   output logic [ADDR_W-1:0] rf_addr_b,
   input  logic [DATA_W-1:0] rf_bus_a,
   input  logic [DATA_W-1:0] rf_bus_b,
   input  logic              wb_wen,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [3:0]        out_op,
   output logic [ADDR_W-1:0] out_dst,
   output logic              out_wen,
   output logic [DATA_W-1:0] out_opa,
   output logic [DATA_W-1:0] out_opb
);

   logic              out_valid_q, out_valid_d;
   op_t               out_op_q, out_op_d;
   logic [ADDR_W-1:0] out_dst_q, out_dst_d;
   logic              out_wen_q, out_wen_d;
   logic [DATA_W-1:0] out_opa_q, out_opa_d;
   logic [DATA_W-1:0] out_opb_q, out_opb_d;

   logic              bypass_a, bypass_b, bypass_d;
   logic [DATA_W-1:0] opa_next, opb_next;
   logic              busy_a, busy_b, busy_d;
   logic              hazard_a, hazard_b, waw, space, issue;

   assign rf_addr_a = in_src_a;
   assign rf_addr_b = in_src_b;

   // The register file commits on the edge, so same-cycle write-back data must be forwarded.
   assign bypass_a = wb_wen && (wb_addr == in_src_a);
   assign bypass_b = wb_wen && (wb_addr == in_src_b);
   assign bypass_d = wb_wen && (wb_addr == in_dst);
   assign opa_next = bypass_a ? wb_data : rf_bus_a;
   assign opb_next = bypass_b ? wb_data : rf_bus_b;

   assign hazard_a = in_uses_a && busy_a && !bypass_a;
   assign hazard_b = in_uses_b && busy_b && !bypass_b;
   assign waw      = in_wen && busy_d && !bypass_d;
   assign space    = !out_valid_q || out_ready;
   assign in_ready = space && !hazard_a && !hazard_b && !waw && !flush;
   assign issue    = in_valid && in_ready;

   reg_scoreboard #(
      .ADDR_W (ADDR_W),
      .NREG   (NREG)
   ) u_sb (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .set_i       (issue && in_wen),
      .set_addr_i  (in_dst),
      .fclr_i      (flush && out_valid_q && out_wen_q),
      .fclr_addr_i (out_dst_q),
      .clr_i       (wb_wen),
      .clr_addr_i  (wb_addr),
      .look_a_i    (in_src_a),
      .look_b_i    (in_src_b),
      .look_d_i    (in_dst),
      .busy_a_o    (busy_a),
      .busy_b_o    (busy_b),
      .busy_d_o    (busy_d)
   );

   always_comb begin
      out_valid_d = out_valid_q;
      out_op_d    = out_op_q;
      out_dst_d   = out_dst_q;
      out_wen_d   = out_wen_q;
      out_opa_d   = out_opa_q;
      out_opb_d   = out_opb_q;
      if (flush) begin
         out_valid_d = 1'b0;
      end else if (issue) begin
         out_valid_d = 1'b1;
         out_op_d    = in_op;
         out_dst_d   = in_dst;
         out_wen_d   = in_wen;
         out_opa_d   = opa_next;
         out_opb_d   = opb_next;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_op_q    <= '0;
         out_dst_q   <= '0;
         out_wen_q   <= 1'b0;
         out_opa_q   <= '0;
         out_opb_q   <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_op_q    <= out_op_d;
         out_dst_q   <= out_dst_d;
         out_wen_q   <= out_wen_d;
         out_opa_q   <= out_opa_d;
         out_opb_q   <= out_opb_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_op    = out_op_q;
   assign out_dst   = out_dst_q;
   assign out_wen   = out_wen_q;
   assign out_opa   = out_opa_q;
   assign out_opb   = out_opb_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage with a behavioural register file in the loop.
module tb_operand_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [3:0]  in_op, in_src_a, in_src_b, in_dst;
   logic        in_uses_a, in_uses_b, in_wen;
   logic [3:0]  rf_addr_a, rf_addr_b;
   logic [15:0] rf_bus_a, rf_bus_b;
   logic        wb_wen;
   logic [3:0]  wb_addr;
   logic [15:0] wb_data;
   logic        flush;
   logic        out_valid, out_ready, out_wen;
   logic [3:0]  out_op, out_dst;
   logic [15:0] out_opa, out_opb;

   int checks   = 0;
   int failures = 0;

   logic [15:0] rf [16];

   always #5 clk = ~clk;

   // Register-file model: combinational read, edge commit; reset loads Rn = n*0x11.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) rf[i] <= 16'(i * 17);
      end else if (wb_wen) begin
         rf[wb_addr] <= wb_data;
      end
   end
   assign rf_bus_a = rf[rf_addr_a];
   assign rf_bus_b = rf[rf_addr_b];

   operand_fetch_stage #(.DATA_W(16), .ADDR_W(4), .NREG(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_src_a(in_src_a), .in_src_b(in_src_b),
      .in_uses_a(in_uses_a), .in_uses_b(in_uses_b),
      .in_dst(in_dst), .in_wen(in_wen),
      .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
      .rf_bus_a(rf_bus_a), .rf_bus_b(rf_bus_b),
      .wb_wen(wb_wen), .wb_addr(wb_addr), .wb_data(wb_data),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
      .out_dst(out_dst), .out_wen(out_wen), .out_opa(out_opa), .out_opb(out_opb)
   );

   typedef struct {
      logic [3:0]  op, a, b;
      logic        ua, ub;
      logic [3:0]  d;
      logic        wbw;
      logic [3:0]  wba;
      logic [15:0] wbd;
      logic [15:0] ea, eb;
   } vec_t;

   vec_t tbl [7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic ua, input logic ub, input logic [3:0] d, input logic w);
      in_op = op; in_src_a = a; in_src_b = b;
      in_uses_a = ua; in_uses_b = ub; in_dst = d; in_wen = w;
   endtask

   task automatic wb(input logic en, input logic [3:0] addr, input logic [15:0] data);
      wb_wen = en; wb_addr = addr; wb_data = data;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0);
      wb(0, 0, 0);
      tbl[0] = '{4'd3,  4'd1,  4'd2,  1'b1, 1'b1, 4'd0, 1'b0, 4'd0,  16'h0000, 16'h0011, 16'h0022};
      tbl[1] = '{4'd4,  4'd5,  4'd15, 1'b1, 1'b1, 4'd1, 1'b1, 4'd5,  16'h1234, 16'h1234, 16'h00FF};
      tbl[2] = '{4'd5,  4'd5,  4'd5,  1'b1, 1'b1, 4'd2, 1'b0, 4'd0,  16'h0000, 16'h1234, 16'h1234};
      tbl[3] = '{4'd6,  4'd0,  4'd15, 1'b1, 1'b1, 4'd3, 1'b1, 4'd15, 16'hABCD, 16'h0000, 16'hABCD};
      tbl[4] = '{4'd7,  4'd3,  4'd4,  1'b1, 1'b1, 4'd4, 1'b1, 4'd9,  16'h9999, 16'h0033, 16'h0044};
      tbl[5] = '{4'd8,  4'd9,  4'd9,  1'b0, 1'b0, 4'd5, 1'b0, 4'd0,  16'h0000, 16'h9999, 16'h9999};
      tbl[6] = '{4'd15, 4'd15, 4'd0,  1'b1, 1'b1, 4'd6, 1'b1, 4'd0,  16'hFFFF, 16'hABCD, 16'hFFFF};

      repeat (2) step();
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_op",    32'(out_op),    32'd0);
      chk("rst_dst",   32'(out_dst),   32'd0);
      chk("rst_wen",   32'(out_wen),   32'd0);
      chk("rst_opa",   32'(out_opa),   32'd0);
      chk("rst_opb",   32'(out_opb),   32'd0);
      rst_n = 1'b1;
      step();

      drive(0, 4'd6, 4'd11, 0, 0, 0, 0);
      #1;
      chk("rf_addr_a", 32'(rf_addr_a), 32'd6);
      chk("rf_addr_b", 32'(rf_addr_b), 32'd11);

      // Table: independent reads, with and without write-back bypass.
      for (int i = 0; i < 7; i++) begin
         drive(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].ua, tbl[i].ub, tbl[i].d, 1'b0);
         wb(tbl[i].wbw, tbl[i].wba, tbl[i].wbd);
         in_valid = 1'b1;
         #1;
         chk($sformatf("v%0d_ready", i), 32'(in_ready), 32'd1);
         step();
         wb(0, 0, 0);
         chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("v%0d_op", i),    32'(out_op),    32'(tbl[i].op));
         chk($sformatf("v%0d_dst", i),   32'(out_dst),   32'(tbl[i].d));
         chk($sformatf("v%0d_wen", i),   32'(out_wen),   32'd0);
         chk($sformatf("v%0d_opa", i),   32'(out_opa),   32'(tbl[i].ea));
         chk($sformatf("v%0d_opb", i),   32'(out_opb),   32'(tbl[i].eb));
      end
      in_valid = 1'b0;
      step();

      // RAW stall on R5 released by write-back, with bypass.
      drive(1, 0, 0, 0, 0, 4'd5, 1); in_valid = 1'b1;
      #1 chk("raw_wr_ready", 32'(in_ready), 32'd1);
      step();
      chk("raw_wr_dst", 32'(out_dst), 32'd5);
      chk("raw_wr_wen", 32'(out_wen), 32'd1);
      drive(2, 4'd5, 0, 1, 0, 0, 0);
      #1 chk("raw_stall0", 32'(in_ready), 32'd0);
      step();
      chk("raw_stall1", 32'(in_ready), 32'd0);
      chk("raw_drain", 32'(out_valid), 32'd0);
      wb(1, 4'd5, 16'hBEEF);
      #1 chk("raw_wb_ready", 32'(in_ready), 32'd1);
      step();
      wb(0, 0, 0);
      chk("raw_valid", 32'(out_valid), 32'd1);
      chk("raw_bypass", 32'(out_opa), 32'hBEEF);
      #1 chk("raw_cleared", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      step();

      // Backpressure hold for three cycles, then back-to-back transfer.
      drive(2, 4'd1, 4'd2, 1, 1, 0, 0); in_valid = 1'b1;
      #1 chk("bp_a_ready", 32'(in_ready), 32'd1);
      step();
      out_ready = 1'b0;
      drive(9, 4'd3, 4'd4, 1, 1, 0, 0);
      for (int k = 0; k < 3; k++) begin
         #1 chk($sformatf("bp_ready%0d", k), 32'(in_ready), 32'd0);
         step();
         chk($sformatf("bp_valid%0d", k), 32'(out_valid), 32'd1);
         chk($sformatf("bp_op%0d", k),    32'(out_op),    32'd2);
         chk($sformatf("bp_opa%0d", k),   32'(out_opa),   32'h0011);
         chk($sformatf("bp_opb%0d", k),   32'(out_opb),   32'h0022);
      end
      out_ready = 1'b1;
      #1 chk("bp_release_ready", 32'(in_ready), 32'd1);
      step();
      chk("bp_b2b_valid", 32'(out_valid), 32'd1);
      chk("bp_b2b_op",    32'(out_op),    32'd9);
      chk("bp_b2b_opa",   32'(out_opa),   32'h0033);
      chk("bp_b2b_opb",   32'(out_opb),   32'h0044);
      in_valid = 1'b0;
      step();

      // New claim on R7 wins over same-cycle write-back of the older R7 write.
      drive(1, 0, 0, 0, 0, 4'd7, 1); in_valid = 1'b1;
      #1 chk("sw_first_ready", 32'(in_ready), 32'd1);
      step();
      wb(1, 4'd7, 16'h7777);
      #1 chk("sw_waw_bypass_ready", 32'(in_ready), 32'd1);
      step();
      wb(0, 0, 0);
      drive(3, 4'd7, 0, 1, 0, 0, 0);
      #1 chk("sw_set_wins0", 32'(in_ready), 32'd0);
      step();
      chk("sw_set_wins1", 32'(in_ready), 32'd0);
      wb(1, 4'd7, 16'h7A7A);
      #1 chk("sw_release_ready", 32'(in_ready), 32'd1);
      step();
      wb(0, 0, 0);
      chk("sw_opa", 32'(out_opa), 32'h7A7A);
      in_valid = 1'b0;
      step();

      // Flush of a held writer releases its busy bit.
      out_ready = 1'b0;
      drive(1, 0, 0, 0, 0, 4'd9, 1); in_valid = 1'b1;
      #1 chk("fl_wr_ready", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      chk("fl_held_valid", 32'(out_valid), 32'd1);
      chk("fl_held_dst",   32'(out_dst),   32'd9);
      flush = 1'b1;
      #1 chk("fl_ready", 32'(in_ready), 32'd0);
      step();
      flush = 1'b0;
      chk("fl_valid", 32'(out_valid), 32'd0);
      out_ready = 1'b1;
      drive(4, 4'd9, 4'd9, 1, 1, 0, 0); in_valid = 1'b1;
      #1 chk("fl_reader_ready", 32'(in_ready), 32'd1);
      step();
      chk("fl_reader_opa", 32'(out_opa), 32'h9999);
      chk("fl_reader_opb", 32'(out_opb), 32'h9999);
      in_valid = 1'b0;
      step();

      // Asynchronous reset in the middle of a stall on R3.
      out_ready = 1'b0;
      drive(1, 0, 0, 0, 0, 4'd3, 1); in_valid = 1'b1;
      #1;
      step();
      drive(2, 4'd3, 0, 1, 0, 0, 0);
      #1 chk("ar_stall", 32'(in_ready), 32'd0);
      chk("ar_pre_opa", 32'(out_opa), 32'hFFFF);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_valid", 32'(out_valid), 32'd0);
      chk("ar_opa",   32'(out_opa),   32'd0);
      chk("ar_dst",   32'(out_dst),   32'd0);
      chk("ar_wen",   32'(out_wen),   32'd0);
      chk("ar_busy_clear", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      step();
      rst_n = 1'b1;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
